// File: rtl/pwm_motor_pkg.sv
// Shared types and constants for the multi-channel motor PWM controller.
package pwm_motor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } ch_state_e;

  // Bit positions of the board keys on the KEY bus.
  localparam int K_INC   = 0;
  localparam int K_DEC   = 1;
  localparam int K_START = 2;
  localparam int K_STOP  = 3;

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: 2-flop synchroniser, stable-level counter and a
// one-cycle pulse when an accepted transition lands on the pressed (low) level.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] stable_cnt;

  // Bring the asynchronous key into the clock domain; idle level is released (1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level only after it differs from the debounced one for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level      <= 1'b1;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_p1 != level) begin
        if (stable_cnt == CNT_LAST) begin
          level      <= sync_p1;
          stable_cnt <= '0;
          press      <= ~sync_p1;
        end else begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pwm_motor_ctrl.sv
// N-channel motor PWM controller: debounced keys steer setpoint changes and
// start/stop to one channel; each channel soft-ramps its applied duty toward
// its setpoint and drives a period-aligned PWM output.
module pwm_motor_ctrl
  import pwm_motor_pkg::*;
#(
  parameter int  N_CH         = 2,
  parameter int  DUTY_W       = 8,
  parameter int  STEP         = 16,
  parameter int  DUTY_INIT    = 128,
  parameter int  DEBOUNCE_CYC = 500000,
  parameter int  RAMP_DIV     = 50000,
  parameter int  PRESC        = 1,
  localparam int SEL_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        KEY,
  input  logic [SEL_W-1:0]  ch_sel,
  output logic [N_CH-1:0]   pwm_out,
  output logic [N_CH-1:0]   running,
  output logic [DUTY_W-1:0] duty_sel
);

  localparam int DW1     = DUTY_W + 1;
  localparam int RAMP_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;

  localparam logic [DUTY_W-1:0]  MAX_V      = '1;
  localparam logic [DUTY_W-1:0]  CNT_LAST   = MAX_V - DUTY_W'(1);
  localparam logic [DUTY_W-1:0]  SP_INIT    = DUTY_W'(DUTY_INIT);
  localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);

  // Setpoint + STEP, clamped at full scale.
  function automatic logic [DUTY_W-1:0] sat_inc(input logic [DUTY_W-1:0] v);
    logic [DW1-1:0] s;
    s = {1'b0, v} + DW1'(STEP);
    sat_inc = (s > {1'b0, MAX_V}) ? MAX_V : s[DUTY_W-1:0];
  endfunction

  // Setpoint - STEP, clamped at zero (sign bit of the widened difference).
  function automatic logic [DUTY_W-1:0] sat_dec(input logic [DUTY_W-1:0] v);
    logic signed [DW1-1:0] s;
    s = $signed({1'b0, v}) - $signed(DW1'(STEP));
    sat_dec = s[DW1-1] ? '0 : s[DUTY_W-1:0];
  endfunction

  logic [3:0] press;
  logic       ev_inc, ev_dec, ev_start, ev_stop;
  logic       sel_ok;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .key  (KEY[k]),
      .press(press[k])
    );
  end

  // At most one event per cycle: stop beats start beats increase beats decrease.
  always_comb begin
    ev_stop  = press[K_STOP];
    ev_start = press[K_START] & ~press[K_STOP];
    ev_inc   = press[K_INC] & ~press[K_START] & ~press[K_STOP];
    ev_dec   = press[K_DEC] & ~press[K_INC] & ~press[K_START] & ~press[K_STOP];
  end

  assign sel_ok = (int'(ch_sel) < N_CH);

  logic [RAMP_W-1:0]  ramp_cnt;
  logic [PRESC_W-1:0] presc_cnt;
  logic [DUTY_W-1:0]  pwm_cnt;
  logic               ramp_tick;
  logic               pwm_tick;
  logic               period_start;

  assign ramp_tick    = (ramp_cnt == RAMP_LAST);
  assign pwm_tick     = (presc_cnt == PRESC_LAST);
  assign period_start = pwm_tick && (pwm_cnt == '0);

  // Shared timebases: ramp divider, PWM prescaler and PWM period counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ramp_cnt  <= '0;
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      ramp_cnt  <= ramp_tick ? '0 : ramp_cnt + RAMP_W'(1);
      presc_cnt <= pwm_tick ? '0 : presc_cnt + PRESC_W'(1);
      if (pwm_tick) begin
        pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + DUTY_W'(1);
      end
    end
  end

  logic [DUTY_W-1:0] applied_all [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ch_state_e         state, state_nxt;
    logic [DUTY_W-1:0] sp;
    logic [DUTY_W-1:0] applied;
    logic [DUTY_W-1:0] duty_q;
    logic              pwm_q;
    logic              hit;
    logic              ch_inc, ch_dec, ch_start, ch_stop;
    logic              step_up, step_dn;

    assign hit      = sel_ok && (int'(ch_sel) == c);
    assign ch_inc   = hit && ev_inc;
    assign ch_dec   = hit && ev_dec;
    assign ch_start = hit && ev_start;
    assign ch_stop  = hit && ev_stop;

    // Channel state register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= IDLE;
      end else begin
        state <= state_nxt;
      end
    end

    // Next state; RAMP_UP uses >= so a setpoint lowered mid-ramp still hands over to RUN.
    always_comb begin
      state_nxt = state;
      unique case (state)
        IDLE:      if (ch_start) state_nxt = RAMP_UP;
        RAMP_UP:   if (ch_stop) state_nxt = RAMP_DOWN;
                   else if (applied >= sp) state_nxt = RUN;
        RUN:       if (ch_stop) state_nxt = RAMP_DOWN;
        RAMP_DOWN: if (ch_start) state_nxt = RAMP_UP;
                   else if (applied == '0) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end

    // Ramp direction for the applied duty in each state.
    always_comb begin
      step_up = 1'b0;
      step_dn = 1'b0;
      unique case (state)
        RAMP_UP:   step_up = ramp_tick && (applied < sp);
        RUN: begin
          step_up = ramp_tick && (applied < sp);
          step_dn = ramp_tick && (applied > sp);
        end
        RAMP_DOWN: step_dn = ramp_tick && (applied != '0);
        default: ;
      endcase
    end

    // Setpoint, applied duty and period-aligned duty latch.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sp      <= SP_INIT;
        applied <= '0;
        duty_q  <= '0;
      end else begin
        if (ch_inc) begin
          sp <= sat_inc(sp);
        end else if (ch_dec) begin
          sp <= sat_dec(sp);
        end
        if (step_up) begin
          applied <= applied + DUTY_W'(1);
        end else if (step_dn) begin
          applied <= applied - DUTY_W'(1);
        end
        if (period_start) begin
          duty_q <= applied;
        end
      end
    end

    // Registered PWM compare, held low while the channel is idle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pwm_q <= 1'b0;
      end else begin
        pwm_q <= (state != IDLE) && (duty_q > pwm_cnt);
      end
    end

    assign pwm_out[c]     = pwm_q;
    assign running[c]     = (state != IDLE);
    assign applied_all[c] = applied;
  end

  // Display mux of the selected channel's applied duty; out-of-range selects read 0.
  always_comb begin
    duty_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(ch_sel) == i) duty_sel = applied_all[i];
    end
  end

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
// Bench for pwm_motor_ctrl: directed scenarios plus a randomised key sequence
// checked at settled points against an abstract setpoint/on-off model.
module tb_pwm_motor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] KEY;
  logic [0:0] ch_sel;
  logic [1:0] pwm_out;
  logic [1:0] running;
  logic [3:0] duty_sel;

  int n_cmp = 0;
  int n_bad = 0;

  // Abstract model: setpoint and whether the channel is (settled) running.
  int sp [2];
  int on [2];

  pwm_motor_ctrl #(
    .N_CH(2), .DUTY_W(4), .STEP(4), .DUTY_INIT(8),
    .DEBOUNCE_CYC(4), .RAMP_DIV(2), .PRESC(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .KEY     (KEY),
    .ch_sel  (ch_sel),
    .pwm_out (pwm_out),
    .running (running),
    .duty_sel(duty_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k, input int c);
    ch_sel = 1'(c);
    KEY[k] = 1'b0;
    tick(10);
    KEY[k] = 1'b1;
    tick(10);
  endtask

  task automatic apply_model(input int k, input int c);
    case (k)
      0: sp[c] = (sp[c] + 4 > 15) ? 15 : sp[c] + 4;
      1: sp[c] = (sp[c] < 4) ? 0 : sp[c] - 4;
      2: on[c] = 1;
      default: on[c] = 0;
    endcase
  endtask

  task automatic op(input int k, input int c);
    press(k, c);
    apply_model(k, c);
    tick(40);
  endtask

  task automatic pwm_count(input int c, input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      cnt += int'(pwm_out[c]);
    end
  endtask

  task automatic check_all(input string tag);
    int hi;
    for (int c = 0; c < 2; c++) begin
      ch_sel = 1'(c);
      #1;
      check({tag, "_running"}, running[c], on[c]);
      check({tag, "_duty"}, duty_sel, on[c] ? sp[c] : 0);
      pwm_count(c, 15, hi);
      check({tag, "_pwm_hi"}, hi, on[c] ? sp[c] : 0);
    end
  endtask

  initial begin
    int prev, cur, last_chg, p1_hi, hi;
    int min_d, drop, started, st_cyc, found;

    rst    = 1'b0;
    KEY    = 4'hF;
    ch_sel = 1'b0;
    for (int c = 0; c < 2; c++) begin
      sp[c] = 8;
      on[c] = 0;
    end
    tick(3);
    check("rst_running", running, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_duty", duty_sel, 0);
    rst = 1'b1;
    tick(2);

    // Start ch0 and watch the soft ramp: +1 LSB every RAMP_DIV cycles.
    ch_sel   = 1'b0;
    KEY[2]   = 1'b0;
    prev     = 0;
    last_chg = -1;
    p1_hi    = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (cyc == 10) KEY[2] = 1'b1;
      cur = int'(duty_sel);
      p1_hi += int'(pwm_out[1]);
      if (cur != prev) begin
        check("ramp_step", cur, prev + 1);
        if (last_chg >= 0) check("ramp_gap", cyc - last_chg, 2);
        last_chg = cyc;
        prev     = cur;
      end
    end
    on[0] = 1;
    check("start_running", running, 2'b01);
    check("start_final", duty_sel, 8);
    check("ch1_quiet", p1_hi, 0);
    pwm_count(0, 15, hi);
    check("start_pwm_hi", hi, 8);

    // Bounce: three 3-cycle glitches are rejected, one steady press is accepted.
    ch_sel = 1'b0;
    for (int g = 0; g < 3; g++) begin
      KEY[0] = 1'b0;
      tick(3);
      KEY[0] = 1'b1;
      tick(5);
    end
    KEY[0] = 1'b0;
    tick(20);
    KEY[0] = 1'b1;
    tick(10);
    apply_model(0, 0);
    tick(40);
    check_all("bounce");

    // ch1: saturate at full scale, start, then drive down to zero while running.
    for (int i = 0; i < 4; i++) op(0, 1);
    op(2, 1);
    check_all("ch1_full");
    pwm_count(1, 30, hi);
    check("ch1_const1", hi, 30);
    for (int i = 0; i < 5; i++) op(1, 1);
    check_all("ch1_zero");
    check("ch1_zero_running", running, 2'b11);
    pwm_count(1, 30, hi);
    check("ch1_const0", hi, 0);

    // Stop ch0 in RUN, restart part-way down: resumes from the current duty.
    ch_sel  = 1'b0;
    KEY[3]  = 1'b0;
    min_d   = 99;
    drop    = 0;
    started = 0;
    st_cyc  = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (cyc == 10) KEY[3] = 1'b1;
      if (started == 0 && int'(duty_sel) <= 9) begin
        KEY[2]  = 1'b0;
        started = 1;
        st_cyc  = cyc;
      end
      if (started == 1 && cyc == st_cyc + 10) KEY[2] = 1'b1;
      if (int'(duty_sel) < min_d) min_d = int'(duty_sel);
      if (!running[0]) drop = 1;
    end
    KEY[2] = 1'b1;
    check("restart_seen_down", started, 1);
    check("restart_no_zero", (min_d > 0), 1);
    check("restart_dipped", (min_d < 10), 1);
    check("restart_kept_running", drop, 0);
    tick(20);
    check_all("restart");

    // Stop ch0, then start+stop in the same cycle on idle ch0: stop wins.
    op(3, 0);
    check_all("stopped");
    ch_sel = 1'b0;
    KEY[2] = 1'b0;
    KEY[3] = 1'b0;
    tick(10);
    KEY[2] = 1'b1;
    KEY[3] = 1'b1;
    tick(50);
    check_all("start_stop_same");

    // Routing: an increase on ch1 must not touch ch0.
    op(0, 1);
    check_all("route_ch1");

    // Randomised key sequence against the model.
    for (int i = 0; i < 24; i++) begin
      int k, c;
      k = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 1));
      op(k, c);
      check_all("rand");
    end

    // Asynchronous reset in RAMP_UP with ch0's PWM output high.
    if (on[0] != 0) op(3, 0);
    while (sp[0] < 12) op(0, 0);
    ch_sel = 1'b0;
    KEY[2] = 1'b0;
    found  = 0;
    for (int cyc = 0; cyc < 80 && found == 0; cyc++) begin
      @(negedge clk);
      if (pwm_out[0] && running[0] && int'(duty_sel) < sp[0]) found = 1;
    end
    check("rst_window_found", found, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_pwm", pwm_out, 0);
    check("async_rst_running", running, 0);
    check("async_rst_duty", duty_sel, 0);
    KEY[2] = 1'b1;
    tick(2);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sp[c] = 8;
      on[c] = 0;
    end
    tick(10);
    check_all("post_rst");
    op(2, 0);
    check_all("post_rst_start");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
